// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: oversampling SPI slave that glitch-filters CS/SCK and assembles
// WORDS x WORD_BITS frames, MSB first, flagging aborted and overrun frames.
module spi_frame_receiver #(
   parameter int unsigned WORD_BITS = 16,
   parameter int unsigned WORDS     = 2,
   parameter bit          CPOL      = 1'b0,
   parameter bit          CPHA      = 1'b0,
   parameter int unsigned FILTER    = 2
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_spi_cs,
   input  logic                       i_spi_sck,
   input  logic                       i_spi_mosi,
   output logic [WORDS*WORD_BITS-1:0] o_frame,
   output logic                       o_frame_valid,
   output logic                       o_frame_error,
   output logic                       o_busy
);
   localparam int unsigned FRAME_W = WORDS * WORD_BITS;
   localparam int unsigned BIT_W   = $clog2(WORD_BITS);
   localparam int unsigned WCNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RECEIVE, WAIT_CS} state_t;

   logic               cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
   logic               sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d;
   logic               mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
   logic [1:0]         fill_q, fill_d;
   logic               cs_f_q, cs_f_d, cs_f_prev_q, cs_f_prev_d;
   logic               sck_f_q, sck_f_d, sck_f_prev_q, sck_f_prev_d;
   logic [3:0]         cs_fcnt_q, cs_fcnt_d, sck_fcnt_q, sck_fcnt_d;
   logic [FILTER-1:0]  mosi_dly_q, mosi_dly_d;
   state_t             state_q, state_d;
   logic               armed_q, armed_d;
   logic               overrun_q, overrun_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [WORD_BITS-1:0] shift_q, shift_d;
   logic [FRAME_W-1:0] staging_q, staging_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               valid_q, valid_d, error_q, error_d, busy_q, busy_d;
   logic               cs_rise, cs_fall, lead, trail, samp, mosi_bit;

   // Returns {level, count}: level flips only after FILTER consecutive differing samples.
   function automatic logic [4:0] filter_step(input logic level, input logic sample,
                                              input logic [3:0] cnt);
      logic [4:0] r;
      r = {level, 4'd0};
      if (sample != level) begin
         if (cnt == 4'(FILTER - 1)) r = {sample, 4'd0};
         else                       r = {level, cnt + 4'd1};
      end
      return r;
   endfunction

   always_comb begin
      cs_s1_d   = i_spi_cs;
      cs_s2_d   = cs_s1_q;
      sck_s1_d  = i_spi_sck;
      sck_s2_d  = sck_s1_q;
      mosi_s1_d = i_spi_mosi;
      mosi_s2_d = mosi_s1_q;
      fill_d    = {fill_q[0], 1'b1};
      {cs_f_d, cs_fcnt_d}   = filter_step(cs_f_q, cs_s2_q, cs_fcnt_q);
      {sck_f_d, sck_fcnt_d} = filter_step(sck_f_q, sck_s2_q, sck_fcnt_q);
      cs_f_prev_d  = cs_f_q;
      sck_f_prev_d = sck_f_q;
      mosi_dly_d   = FILTER'({mosi_dly_q, mosi_s2_q});

      cs_rise  = ~cs_f_prev_q & cs_f_q;
      cs_fall  = cs_f_prev_q & ~cs_f_q;
      lead     = (sck_f_prev_q == CPOL) && (sck_f_q != CPOL);
      trail    = (sck_f_prev_q != CPOL) && (sck_f_q == CPOL);
      samp     = CPHA ? trail : lead;
      mosi_bit = mosi_dly_q[FILTER-1];
      // Arming waits for the synchroniser to hold real pin data, so a CS held low
      // through reset release is not mistaken for a fresh falling edge.
      armed_d  = armed_q | (fill_q[1] & cs_s2_q & cs_f_q);

      state_d    = state_q;
      overrun_d  = overrun_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      shift_d    = shift_q;
      staging_d  = staging_q;
      frame_d    = frame_q;
      valid_d    = 1'b0;
      error_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cs_fall && armed_q) begin
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               overrun_d  = 1'b0;
               state_d    = RECEIVE;
            end
         end
         RECEIVE: begin
            if (cs_rise) begin
               error_d = (bit_cnt_q != '0) || (word_cnt_q != '0);
               state_d = IDLE;
            end else if (samp) begin
               shift_d = {shift_q[WORD_BITS-2:0], mosi_bit};
               if (bit_cnt_q == BIT_W'(WORD_BITS - 1)) begin
                  bit_cnt_d = '0;
                  // Words arrive in index order, so shifting in from the top leaves
                  // word k at slot k once all WORDS words have been received.
                  staging_d = FRAME_W'({shift_d, staging_q} >> WORD_BITS);
                  if (word_cnt_q == WCNT_W'(WORDS - 1)) begin
                     frame_d = staging_d;
                     valid_d = 1'b1;
                     state_d = WAIT_CS;
                  end else begin
                     word_cnt_d = word_cnt_q + WCNT_W'(1);
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         WAIT_CS: begin
            if (samp) overrun_d = 1'b1;
            if (cs_rise) begin
               error_d = overrun_d;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         cs_s1_q      <= 1'b1;
         cs_s2_q      <= 1'b1;
         sck_s1_q     <= CPOL;
         sck_s2_q     <= CPOL;
         mosi_s1_q    <= 1'b0;
         mosi_s2_q    <= 1'b0;
         fill_q       <= '0;
         cs_f_q       <= 1'b1;
         cs_f_prev_q  <= 1'b1;
         sck_f_q      <= CPOL;
         sck_f_prev_q <= CPOL;
         cs_fcnt_q    <= '0;
         sck_fcnt_q   <= '0;
         mosi_dly_q   <= '0;
         state_q      <= IDLE;
         armed_q      <= 1'b0;
         overrun_q    <= 1'b0;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         shift_q      <= '0;
         staging_q    <= '0;
         frame_q      <= '0;
         valid_q      <= 1'b0;
         error_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         cs_s1_q      <= cs_s1_d;
         cs_s2_q      <= cs_s2_d;
         sck_s1_q     <= sck_s1_d;
         sck_s2_q     <= sck_s2_d;
         mosi_s1_q    <= mosi_s1_d;
         mosi_s2_q    <= mosi_s2_d;
         fill_q       <= fill_d;
         cs_f_q       <= cs_f_d;
         cs_f_prev_q  <= cs_f_prev_d;
         sck_f_q      <= sck_f_d;
         sck_f_prev_q <= sck_f_prev_d;
         cs_fcnt_q    <= cs_fcnt_d;
         sck_fcnt_q   <= sck_fcnt_d;
         mosi_dly_q   <= mosi_dly_d;
         state_q      <= state_d;
         armed_q      <= armed_d;
         overrun_q    <= overrun_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         shift_q      <= shift_d;
         staging_q    <= staging_d;
         frame_q      <= frame_d;
         valid_q      <= valid_d;
         error_q      <= error_d;
         busy_q       <= busy_d;
      end
   end

   assign o_frame       = frame_q;
   assign o_frame_valid = valid_q;
   assign o_frame_error = error_q;
   assign o_busy        = busy_q;

endmodule
